// File: rtl/operand_packer_if.sv
// Handshake and vector bus between the element feeder, the operand packer
// and the compute stage. master = feeder/compute side, slave = packer.
interface operand_packer_if #(
  parameter int N_ELEM = 16,
  parameter int DATA_W = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_W-1:0]        in_a;
  logic [DATA_W-1:0]        in_b;
  logic                     out_valid;
  logic                     out_ready;
  logic [N_ELEM*DATA_W-1:0] A;
  logic [N_ELEM*DATA_W-1:0] B;
  logic [7:0]               vec_cnt;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, A, B, vec_cnt
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, A, B, vec_cnt
  );
endinterface

// File: rtl/operand_packer.sv
// operand_packer: collects N_ELEM A/B element pairs into packed vectors and
// hands them to the compute stage through a one-deep output slot. A second
// complete vector can wait in the pack buffer while the slot is occupied.
// Optional feature: define PACK_FLUSH_EN to add a flush input that closes a
// partially filled vector, padding the unwritten lanes with zero.
module operand_packer #(
  parameter int N_ELEM = 16,
  parameter int DATA_W = 8
) (
  input  logic clk,
  input  logic rst,
`ifdef PACK_FLUSH_EN
  input  logic flush,
`endif
  operand_packer_if.slave bus
);
  localparam int VEC_W = N_ELEM * DATA_W;
  localparam int CNT_W = $clog2(N_ELEM + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_ELEM);

  logic [CNT_W-1:0] count, nxt_count, post_cnt;
  logic [VEC_W-1:0] buf_a, buf_b, nxt_buf_a, nxt_buf_b;
  logic [VEC_W-1:0] fill_a, fill_b, xfer_a, xfer_b;
  logic [VEC_W-1:0] a_q, b_q;
  logic             out_valid_q;
  logic [7:0]       vec_cnt_q;
  logic             slot_free, full, ready, accept, handoff, transfer;

  assign slot_free = !out_valid_q || bus.out_ready;
  assign full      = (count == CNT_FULL);
  assign ready     = !rst && (!full || slot_free);
  assign accept    = bus.in_valid && ready;
  assign handoff   = out_valid_q && bus.out_ready;

  assign bus.in_ready  = ready;
  assign bus.out_valid = out_valid_q;
  assign bus.A         = a_q;
  assign bus.B         = b_q;
  assign bus.vec_cnt   = vec_cnt_q;

  // Next pack-buffer state, and whether a vector moves into the output slot.
  always_comb begin
    fill_a    = buf_a;
    fill_b    = buf_b;
    post_cnt  = count;
    xfer_a    = buf_a;
    xfer_b    = buf_b;
    transfer  = 1'b0;
    nxt_buf_a = buf_a;
    nxt_buf_b = buf_b;
    nxt_count = count;
    if (full) begin
      // A held vector leaves first; an element accepted now starts a new one.
      if (slot_free) begin
        transfer  = 1'b1;
        nxt_buf_a = '0;
        nxt_buf_b = '0;
        nxt_count = '0;
        if (accept) begin
          nxt_buf_a[DATA_W-1:0] = bus.in_a;
          nxt_buf_b[DATA_W-1:0] = bus.in_b;
          nxt_count             = CNT_W'(1);
        end
      end
    end else if (accept) begin
      fill_a[int'(count)*DATA_W +: DATA_W] = bus.in_a;
      fill_b[int'(count)*DATA_W +: DATA_W] = bus.in_b;
      post_cnt = count + CNT_W'(1);
      if (post_cnt == CNT_FULL) begin
        if (slot_free) begin
          // Completed vector bypasses the buffer straight into the slot.
          transfer  = 1'b1;
          xfer_a    = fill_a;
          xfer_b    = fill_b;
          nxt_buf_a = '0;
          nxt_buf_b = '0;
          nxt_count = '0;
        end else begin
          nxt_buf_a = fill_a;
          nxt_buf_b = fill_b;
          nxt_count = CNT_FULL;
        end
      end else begin
        nxt_buf_a = fill_a;
        nxt_buf_b = fill_b;
        nxt_count = post_cnt;
`ifdef PACK_FLUSH_EN
        // Unwritten lanes are already zero, so closing the vector is enough.
        if (flush) nxt_count = CNT_FULL;
`endif
      end
    end
`ifdef PACK_FLUSH_EN
    else if (flush && count != '0) begin
      nxt_count = CNT_FULL;
    end
`endif
  end

  // Register the pack buffer, output slot and handoff counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      buf_a       <= '0;
      buf_b       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
      vec_cnt_q   <= '0;
    end else begin
      count <= nxt_count;
      buf_a <= nxt_buf_a;
      buf_b <= nxt_buf_b;
      if (handoff) vec_cnt_q <= vec_cnt_q + 8'd1;
      if (transfer) begin
        a_q         <= xfer_a;
        b_q         <= xfer_b;
        out_valid_q <= 1'b1;
      end else if (handoff) begin
        out_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_operand_packer.sv
// Bench for operand_packer: directed scenarios plus random traffic, checked
// against a queue model of accepted elements and pending complete vectors.
module tb_operand_packer;
  localparam int N_ELEM = 16;
  localparam int DATA_W = 8;
  localparam int VEC_W  = N_ELEM * DATA_W;

  logic clk = 1'b0;
  logic rst;
`ifdef PACK_FLUSH_EN
  logic flush;
`endif

  operand_packer_if #(.N_ELEM(N_ELEM), .DATA_W(DATA_W)) bus ();

  operand_packer #(.N_ELEM(N_ELEM), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef PACK_FLUSH_EN
    .flush (flush),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: elements of the vector being filled, and complete vectors that
  // have not yet been handed to the compute stage (slot + held buffer).
  logic [DATA_W-1:0] elem_a_q[$];
  logic [DATA_W-1:0] elem_b_q[$];
  logic [VEC_W-1:0]  vec_a_q[$];
  logic [VEC_W-1:0]  vec_b_q[$];
  int                handoffs = 0;
  logic              got;

  task automatic chk(input string tag, input logic [VEC_W-1:0] obs,
                     input logic [VEC_W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    elem_a_q.delete();
    elem_b_q.delete();
    vec_a_q.delete();
    vec_b_q.delete();
    handoffs = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.out_ready = 1'b0;
    #1;
    chk("in_ready_in_reset", VEC_W'(bus.in_ready), VEC_W'(0));
    @(posedge clk); #1;
    chk("rst_out_valid", VEC_W'(bus.out_valid), VEC_W'(0));
    chk("rst_A", bus.A, '0);
    chk("rst_B", bus.B, '0);
    chk("rst_vec_cnt", VEC_W'(bus.vec_cnt), VEC_W'(0));
    rst = 1'b0;
    model_clear();
  endtask

  // One clock cycle of traffic, checked against the model.
  task automatic cycle(input logic v, input logic [DATA_W-1:0] a,
                       input logic [DATA_W-1:0] b, input logic ordy,
                       output logic acc);
    logic exp_rdy, hs;
    logic [VEC_W-1:0] va, vb;
    bus.in_valid = v;
    bus.in_a = a;
    bus.in_b = b;
    bus.out_ready = ordy;
    #1;
    // Room exists unless a whole vector already waits behind the slot.
    exp_rdy = (vec_a_q.size() < 2) || ordy;
    chk("in_ready", VEC_W'(bus.in_ready), VEC_W'(exp_rdy));
    acc = v && exp_rdy;
    hs = (vec_a_q.size() > 0) && ordy;
    if (hs) begin
      chk("A_at_handoff", bus.A, vec_a_q[0]);
      chk("B_at_handoff", bus.B, vec_b_q[0]);
    end
    @(posedge clk); #1;
    if (hs) begin
      void'(vec_a_q.pop_front());
      void'(vec_b_q.pop_front());
      handoffs++;
    end
    if (acc) begin
      elem_a_q.push_back(a);
      elem_b_q.push_back(b);
      if (elem_a_q.size() == N_ELEM) begin
        va = '0;
        vb = '0;
        for (int k = 0; k < N_ELEM; k++) begin
          va = va | (VEC_W'(elem_a_q[k]) << (k * DATA_W));
          vb = vb | (VEC_W'(elem_b_q[k]) << (k * DATA_W));
        end
        vec_a_q.push_back(va);
        vec_b_q.push_back(vb);
        elem_a_q.delete();
        elem_b_q.delete();
      end
    end
    chk("out_valid", VEC_W'(bus.out_valid), VEC_W'(vec_a_q.size() > 0));
    chk("vec_cnt", VEC_W'(bus.vec_cnt), VEC_W'(handoffs % 256));
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b1, got);
  endtask

  logic [DATA_W-1:0] bp_a[40];
  logic [DATA_W-1:0] bp_b[40];
  int               idx;
  logic [VEC_W-1:0] av, bv;
  int               dot;

  initial begin
`ifdef PACK_FLUSH_EN
    flush = 1'b0;
`endif
    do_reset();

    // Back-to-back counting pattern
    for (int k = 0; k < 16; k++)
      cycle(1'b1, 8'(k), 8'(8'hFF - k), 1'b1, got);
    chk("b2b_A", bus.A, 128'h0F0E0D0C0B0A09080706050403020100);
    chk("b2b_B", bus.B, 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);
    drain(1);
    chk("b2b_vec_cnt", VEC_W'(bus.vec_cnt), VEC_W'(1));
    drain(2);

    // Backpressure: 40 offered pairs, only 32 fit while out_ready is low
    for (int i = 0; i < 40; i++) begin
      bp_a[i] = 8'($urandom);
      bp_b[i] = 8'($urandom);
    end
    idx = 0;
    for (int c = 0; c < 40; c++) begin
      cycle(1'b1, bp_a[idx], bp_b[idx], 1'b0, got);
      if (got) idx++;
    end
    chk("bp_accepted", VEC_W'(idx), VEC_W'(32));
    chk("bp_hold_A", bus.A, vec_a_q[0]);
    chk("bp_hold_B", bus.B, vec_b_q[0]);
    for (int c = 0; c < 40 && idx < 40; c++) begin
      cycle(1'b1, bp_a[idx], bp_b[idx], 1'b1, got);
      if (got) idx++;
    end
    chk("bp_all_accepted", VEC_W'(idx), VEC_W'(40));
    drain(4);

    // Random valid/ready traffic
    for (int c = 0; c < 400; c++)
      cycle($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
            $urandom_range(0, 3) != 0, got);
    drain(4);
    do_reset();

    // All-ones vector
    for (int k = 0; k < 16; k++) cycle(1'b1, 8'hFF, 8'hFF, 1'b0, got);
    chk("ones_A", bus.A, {VEC_W{1'b1}});
    chk("ones_B", bus.B, {VEC_W{1'b1}});
    av = bus.A;
    bv = bus.B;
    dot = 0;
    for (int k = 0; k < N_ELEM; k++)
      dot += int'(av[k*DATA_W +: DATA_W]) * int'(bv[k*DATA_W +: DATA_W]);
    chk("ones_dot", VEC_W'(dot), VEC_W'(32'hFE010));
    drain(3);

    // Reset in the middle of a fill
    for (int k = 0; k < 7; k++)
      cycle(1'b1, 8'($urandom), 8'($urandom), 1'b1, got);
    do_reset();
    for (int k = 0; k < 16; k++)
      cycle(1'b1, 8'($urandom), 8'($urandom), 1'b1, got);
    drain(2);

    // Handoff counter wrap
    for (int c = 0; c < 6000 && handoffs < 256; c++)
      cycle(1'b1, 8'($urandom), 8'($urandom), 1'b1, got);
    chk("wrap_handoffs", VEC_W'(handoffs), VEC_W'(256));
    chk("wrap_vec_cnt_0", VEC_W'(bus.vec_cnt), VEC_W'(0));
    for (int c = 0; c < 100 && handoffs < 257; c++)
      cycle(1'b1, 8'($urandom), 8'($urandom), 1'b1, got);
    chk("wrap_vec_cnt_1", VEC_W'(bus.vec_cnt), VEC_W'(1));

`ifdef PACK_FLUSH_EN
    // Flush pads a 5-element vector with zero lanes
    do_reset();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1;
      bus.in_a = 8'h11;
      bus.in_b = 8'h11;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    for (int c = 0; c < 4 && !bus.out_valid; c++) begin
      @(posedge clk); #1;
    end
    chk("flush_out_valid", VEC_W'(bus.out_valid), VEC_W'(1));
    chk("flush_A", bus.A, 128'h0000000000000000000000_1111111111);
    chk("flush_B", bus.B, 128'h0000000000000000000000_1111111111);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
